// File: rtl/vram_arbiter.sv
// vram_arbiter: owns the single VRAM port and shares it between the sprite
// fetcher, the BG/window fetcher and the CPU. Fetchers are served with zero
// latency by fixed priority. The CPU goes through a one-deep pending slot and
// is locked out, as on real hardware, while the PPU is drawing (mode 3).
module vram_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        lcd_en,
    input  logic [1:0]  mode,
    input  logic        spr_req,
    input  logic [15:0] spr_addr,
    input  logic        spr_lock,
    output logic [7:0]  spr_rdata,
    output logic        spr_rvalid,
    input  logic        bg_req,
    input  logic [15:0] bg_addr,
    output logic [7:0]  bg_rdata,
    output logic        bg_rvalid,
    output logic        bg_stall,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic [12:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  stall_cnt,
    output logic [1:0]  arb_state_dbg
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_SPR  = 2'd1,
        GNT_BG   = 2'd2,
        GNT_CPU  = 2'd3
    } grant_t;

    grant_t      grant;
    logic        draw;
    logic        cpu_blocked;
    logic        cpu_done;
    logic        pend_load;
    logic        mode3_entry;

    // CPU pending slot; only the low 13 address bits ever reach VRAM
    logic        pend_reg;
    logic        pend_we_reg;
    logic [12:0] pend_addr_reg;
    logic [7:0]  pend_wdata_reg;

    logic        cpu_ack_reg;
    logic [7:0]  cpu_rdata_reg;
    logic [7:0]  stall_cnt_reg;
    logic [1:0]  mode_q_reg;

    // Upper address bits select the VRAM region upstream and are not decoded here
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{spr_addr[15:13], bg_addr[15:13], cpu_addr[15:13]};

    assign draw = lcd_en & (mode == 2'd3);

    // Fixed-priority grant: sprite, then BG (unless a sprite sequence holds the lock), then CPU
    always_comb begin
        grant = GNT_NONE;
        if (lcd_en & spr_req) begin
            grant = GNT_SPR;
        end else if (lcd_en & bg_req & ~spr_lock) begin
            grant = GNT_BG;
        end else if (pend_reg & ~draw) begin
            grant = GNT_CPU;
        end
    end

    // VRAM port mux and fetcher read returns; idle port parks on the pending CPU address
    always_comb begin
        mem_addr   = pend_addr_reg;
        mem_we     = 1'b0;
        mem_wdata  = pend_wdata_reg;
        spr_rvalid = 1'b0;
        spr_rdata  = 8'hFF;
        bg_rvalid  = 1'b0;
        bg_rdata   = 8'hFF;
        case (grant)
            GNT_SPR: begin
                mem_addr   = spr_addr[12:0];
                spr_rvalid = 1'b1;
                spr_rdata  = mem_rdata;
            end
            GNT_BG: begin
                mem_addr  = bg_addr[12:0];
                bg_rvalid = 1'b1;
                bg_rdata  = mem_rdata;
            end
            GNT_CPU: begin
                mem_we = pend_we_reg;
            end
            default: begin
            end
        endcase
    end

    // A pending access during drawing completes immediately as blocked
    assign cpu_blocked = pend_reg & draw;
    assign cpu_done    = (grant == GNT_CPU) | cpu_blocked;
    // Holding off while ack is high stops the still-asserted request from reloading
    assign pend_load   = cpu_req & ~pend_reg & ~cpu_ack_reg;
    assign mode3_entry = (mode == 2'd3) & (mode_q_reg != 2'd3);

    assign bg_stall      = lcd_en & bg_req & (grant != GNT_BG);
    assign cpu_ack       = cpu_ack_reg;
    assign cpu_rdata     = cpu_rdata_reg;
    assign stall_cnt     = stall_cnt_reg;
    assign arb_state_dbg = grant;

    // CPU pending slot, completion pulse and read-data capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_reg       <= 1'b0;
            pend_we_reg    <= 1'b0;
            pend_addr_reg  <= 13'd0;
            pend_wdata_reg <= 8'd0;
            cpu_ack_reg    <= 1'b0;
            cpu_rdata_reg  <= 8'hFF;
        end else begin
            cpu_ack_reg <= cpu_done;
            if (cpu_done) begin
                pend_reg <= 1'b0;
            end else if (pend_load) begin
                pend_reg       <= 1'b1;
                pend_we_reg    <= cpu_we;
                pend_addr_reg  <= cpu_addr[12:0];
                pend_wdata_reg <= cpu_wdata;
            end
            if ((grant == GNT_CPU) && !pend_we_reg) begin
                cpu_rdata_reg <= mem_rdata;
            end else if (cpu_blocked && !pend_we_reg) begin
                cpu_rdata_reg <= 8'hFF;
            end
        end
    end

    // Saturating count of BG stall cycles, restarted on every entry into mode 3
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_reg <= 8'd0;
            mode_q_reg    <= 2'd0;
        end else begin
            mode_q_reg <= mode;
            if (mode3_entry) begin
                stall_cnt_reg <= 8'd0;
            end else if (bg_stall && (stall_cnt_reg != 8'hFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed stimulus against vram_arbiter with a bench-side
// VRAM, a transaction-level reference model checked every cycle, and
// hand-computed literal expectations for each scenario.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        lcd_en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        spr_req = 1'b0;
    logic [15:0] spr_addr = 16'h8000;
    logic        spr_lock = 1'b0;
    logic [7:0]  spr_rdata;
    logic        spr_rvalid;
    logic        bg_req = 1'b0;
    logic [15:0] bg_addr = 16'h9C00;
    logic [7:0]  bg_rdata;
    logic        bg_rvalid;
    logic        bg_stall;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h8000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [12:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  stall_cnt;
    logic [1:0]  arb_state_dbg;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    vram_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .lcd_en        (lcd_en),
        .mode          (mode),
        .spr_req       (spr_req),
        .spr_addr      (spr_addr),
        .spr_lock      (spr_lock),
        .spr_rdata     (spr_rdata),
        .spr_rvalid    (spr_rvalid),
        .bg_req        (bg_req),
        .bg_addr       (bg_addr),
        .bg_rdata      (bg_rdata),
        .bg_rvalid     (bg_rvalid),
        .bg_stall      (bg_stall),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .cpu_ack       (cpu_ack),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .stall_cnt     (stall_cnt),
        .arb_state_dbg (arb_state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bench VRAM: asynchronous read, write committed at the clock edge
    logic [7:0] vram [0:8191];
    assign mem_rdata = vram[mem_addr];
    always @(posedge clk) begin
        if (mem_we) vram[mem_addr] <= mem_wdata;
    end

    // Reference model state: expected memory contents and the CPU transaction in flight
    logic [7:0]  m_mem [0:8191];
    bit          m_pend = 1'b0;
    bit          m_we = 1'b0;
    logic [15:0] m_addr = 16'h0;
    logic [7:0]  m_wdata = 8'h0;
    bit          m_ack = 1'b0;
    logic [7:0]  m_rdata = 8'hFF;
    int          m_cnt = 0;
    logic [1:0]  m_mode_q = 2'd0;
    int          mw;
    bit          mserved;
    bit          mstall;

    // Who owns the port this cycle: 0 none, 1 sprite, 2 BG, 3 CPU
    function automatic int winner();
        if (lcd_en && spr_req) return 1;
        if (lcd_en && bg_req && !spr_lock) return 2;
        if (m_pend && !(lcd_en && mode == 2'd3)) return 3;
        return 0;
    endfunction

    // Advance the model one cycle using the inputs that were stable before the edge
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pend = 1'b0; m_we = 1'b0; m_addr = 16'h0; m_wdata = 8'h0;
            m_ack = 1'b0; m_rdata = 8'hFF; m_cnt = 0; m_mode_q = 2'd0;
        end else begin
            mw = winner();
            mstall = lcd_en && bg_req && (mw != 2);
            mserved = 1'b0;
            if (mw == 3) begin
                if (m_we) m_mem[m_addr[12:0]] = m_wdata;
                else      m_rdata = m_mem[m_addr[12:0]];
                mserved = 1'b1;
            end else if (m_pend && lcd_en && mode == 2'd3) begin
                if (!m_we) m_rdata = 8'hFF;
                mserved = 1'b1;
            end
            if (mserved) begin
                m_pend = 1'b0;
            end else if (cpu_req && !m_pend && !m_ack) begin
                m_pend = 1'b1; m_we = cpu_we; m_addr = cpu_addr; m_wdata = cpu_wdata;
            end
            m_ack = mserved;
            if (mode == 2'd3 && m_mode_q != 2'd3) m_cnt = 0;
            else if (mstall && m_cnt < 255) m_cnt = m_cnt + 1;
            m_mode_q = mode;
        end
    end

    // Per-cycle comparison of every DUT output against the model
    int cw;
    int ea;
    always @(negedge clk) begin
        if (chk_en) begin
            cw = winner();
            case (cw)
                1: ea = int'(spr_addr[12:0]);
                2: ea = int'(bg_addr[12:0]);
                default: ea = int'(m_addr[12:0]);
            endcase
            chk("arb_state_dbg", int'(arb_state_dbg), cw);
            chk("mem_addr", int'(mem_addr), ea);
            chk("mem_we", int'(mem_we), int'(cw == 3 && m_we));
            if (cw == 3 && m_we) chk("mem_wdata", int'(mem_wdata), int'(m_wdata));
            chk("spr_rvalid", int'(spr_rvalid), int'(cw == 1));
            chk("spr_rdata", int'(spr_rdata), (cw == 1) ? int'(m_mem[spr_addr[12:0]]) : 'hFF);
            chk("bg_rvalid", int'(bg_rvalid), int'(cw == 2));
            chk("bg_rdata", int'(bg_rdata), (cw == 2) ? int'(m_mem[bg_addr[12:0]]) : 'hFF);
            chk("bg_stall", int'(bg_stall), int'(lcd_en && bg_req && cw != 2));
            chk("cpu_ack", int'(cpu_ack), int'(m_ack));
            chk("cpu_rdata", int'(cpu_rdata), int'(m_rdata));
            chk("stall_cnt", int'(stall_cnt), m_cnt);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One CPU access; latency counts cycles from request cycle N to the ack cycle.
    // With bg_coll set, a BG request is raised in the cycle the CPU slot loads.
    task automatic cpu_access(input bit we, input logic [15:0] addr, input logic [7:0] wd,
                              input bit bg_coll, output logic [7:0] rd, output int lat,
                              output int wec, output int wea, output int bgv, output int bgd);
        int k;
        bit done;
        k = 0; done = 1'b0; lat = -1; wec = 0; wea = -1; bgv = 0; bgd = -1; rd = 8'h00;
        cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        while (!done && k < 40) begin
            @(negedge clk);
            if (mem_we) begin
                wec++;
                wea = int'(mem_addr);
            end
            if (bg_coll && k == 1) begin
                bgv = int'(bg_rvalid);
                bgd = int'(bg_rdata);
            end
            if (cpu_ack) begin
                done = 1'b1;
                lat = k;
                rd = cpu_rdata;
            end
            @(posedge clk);
            #1;
            if (bg_coll) begin
                bg_req = (k == 0);
                bg_addr = 16'h9C00;
            end
            k++;
        end
        cpu_req = 1'b0;
        if (!done) chk("cpu_ack_timeout", 0, 1);
    endtask

    logic [7:0] rd;
    int lat, wec, wea, bgv, bgd;
    int n_stall, n_spr, n_ack;

    initial begin
        for (int i = 0; i < 8192; i++) begin
            vram[i]  = 8'(i) ^ 8'hA5;
            m_mem[i] = 8'(i) ^ 8'hA5;
        end
        vram[13'h1800] = 8'h77; m_mem[13'h1800] = 8'h77;
        vram[13'h1C00] = 8'hC3; m_mem[13'h1C00] = 8'hC3;

        // Reset state
        tick(1);
        chk_en = 1'b1;
        tick(2);
        @(negedge clk);
        chk("rst_cpu_rdata", int'(cpu_rdata), 'hFF);
        chk("rst_cpu_ack", int'(cpu_ack), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        @(posedge clk); #1;
        reset_n = 1'b1; lcd_en = 1'b1; mode = 2'd0;
        tick(1);

        // Idle write then read in HBlank
        cpu_access(1'b1, 16'h8010, 8'h5A, 1'b0, rd, lat, wec, wea, bgv, bgd);
        $display("[TB] wr 8010=5A lat=%0d we_cycles=%0d", lat, wec);
        chk("wr_latency", lat, 2);
        chk("wr_we_cycles", wec, 1);
        chk("wr_we_addr", wea, 'h0010);
        tick(1);
        cpu_access(1'b0, 16'h8010, 8'h00, 1'b0, rd, lat, wec, wea, bgv, bgd);
        $display("[TB] rd 8010 -> %02h lat=%0d", rd, lat);
        chk("rd_data", int'(rd), 'h5A);
        chk("rd_latency", lat, 2);
        tick(1);

        // Drawing blocks the CPU
        mode = 2'd3;
        tick(2);
        cpu_access(1'b0, 16'h9800, 8'h00, 1'b0, rd, lat, wec, wea, bgv, bgd);
        $display("[TB] mode3 rd 9800 -> %02h lat=%0d", rd, lat);
        chk("m3_rd_data", int'(rd), 'hFF);
        chk("m3_rd_latency", lat, 2);
        tick(1);
        cpu_access(1'b1, 16'h9800, 8'h11, 1'b0, rd, lat, wec, wea, bgv, bgd);
        $display("[TB] mode3 wr 9800=11 lat=%0d we_cycles=%0d", lat, wec);
        chk("m3_wr_we_cycles", wec, 0);
        chk("m3_wr_latency", lat, 2);
        mode = 2'd0;
        tick(1);
        cpu_access(1'b0, 16'h9800, 8'h00, 1'b0, rd, lat, wec, wea, bgv, bgd);
        $display("[TB] mode0 rd 9800 -> %02h lat=%0d", rd, lat);
        chk("m3_wr_dropped", int'(rd), 'h77);
        tick(1);

        // BG fetch collides with the CPU slot in OAM scan
        mode = 2'd2;
        tick(1);
        cpu_access(1'b0, 16'h8010, 8'h00, 1'b1, rd, lat, wec, wea, bgv, bgd);
        $display("[TB] collision rd 8010 -> %02h lat=%0d bg_rvalid=%0d bg_rdata=%02h", rd, lat, bgv, bgd);
        chk("coll_latency", lat, 3);
        chk("coll_rd_data", int'(rd), 'h5A);
        chk("coll_bg_rvalid", bgv, 1);
        chk("coll_bg_rdata", bgd, 'hC3);
        tick(1);

        // Sprite lock starves BG for 6 cycles
        mode = 2'd3;
        tick(3);
        n_stall = 0; n_spr = 0;
        spr_lock = 1'b1; bg_req = 1'b1; bg_addr = 16'h9C00;
        for (int k = 0; k < 6; k++) begin
            spr_req = (k == 1 || k == 3);
            spr_addr = 16'h8000 + 16'(k);
            @(negedge clk);
            if (bg_stall) n_stall++;
            if (spr_rvalid) n_spr++;
            @(posedge clk); #1;
        end
        spr_req = 1'b0; bg_req = 1'b0; spr_lock = 1'b0;
        @(negedge clk);
        $display("[TB] sprite lock stall_cycles=%0d spr_rvalid=%0d stall_cnt=%0d", n_stall, n_spr, stall_cnt);
        chk("lock_stall_cycles", n_stall, 6);
        chk("lock_spr_rvalid", n_spr, 2);
        chk("lock_stall_cnt", int'(stall_cnt), 6);

        // Saturation and restart on mode 3 re-entry
        @(posedge clk); #1;
        bg_req = 1'b1; spr_lock = 1'b1;
        tick(300);
        bg_req = 1'b0; spr_lock = 1'b0;
        @(negedge clk);
        $display("[TB] stall_cnt after 300 stalls = %0d", stall_cnt);
        chk("cnt_saturate", int'(stall_cnt), 255);
        @(posedge clk); #1;
        mode = 2'd0;
        tick(2);
        chk("cnt_hold", int'(stall_cnt), 255);
        mode = 2'd3;
        tick(1);
        @(negedge clk);
        $display("[TB] stall_cnt after mode3 re-entry = %0d", stall_cnt);
        chk("cnt_reentry_clear", int'(stall_cnt), 0);
        @(posedge clk); #1;

        // Reset while a CPU read waits behind BG
        mode = 2'd0; spr_lock = 1'b0; bg_req = 1'b1; bg_addr = 16'h9C00;
        cpu_we = 1'b0; cpu_addr = 16'h8010; cpu_req = 1'b1;
        tick(3);
        @(negedge clk);
        chk("pre_rst_ack", int'(cpu_ack), 0);
        chk("pre_rst_rdata", int'(cpu_rdata), 'h5A);
        @(posedge clk); #1;
        reset_n = 1'b0; cpu_req = 1'b0; bg_req = 1'b0;
        n_ack = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (cpu_ack) n_ack++;
            @(posedge clk); #1;
            if (k == 2) reset_n = 1'b1;
        end
        $display("[TB] reset mid-access acks=%0d cpu_rdata=%02h", n_ack, cpu_rdata);
        chk("rst_mid_no_ack", n_ack, 0);
        chk("rst_mid_rdata", int'(cpu_rdata), 'hFF);

        // LCD off: fetchers ignored even in mode 3, CPU served
        lcd_en = 1'b0; mode = 2'd3; bg_req = 1'b1; bg_addr = 16'h9C00;
        @(negedge clk);
        chk("lcdoff_bg_rvalid", int'(bg_rvalid), 0);
        chk("lcdoff_bg_stall", int'(bg_stall), 0);
        @(posedge clk); #1;
        cpu_access(1'b1, 16'h8020, 8'h99, 1'b0, rd, lat, wec, wea, bgv, bgd);
        $display("[TB] lcd off wr 8020=99 lat=%0d we_cycles=%0d", lat, wec);
        chk("lcdoff_wr_latency", lat, 2);
        chk("lcdoff_wr_we_cycles", wec, 1);
        tick(1);
        cpu_access(1'b0, 16'h8020, 8'h00, 1'b0, rd, lat, wec, wea, bgv, bgd);
        $display("[TB] lcd off rd 8020 -> %02h lat=%0d", rd, lat);
        chk("lcdoff_rd_data", int'(rd), 'h99);
        chk("lcdoff_rd_latency", lat, 2);

        bg_req = 1'b0;
        tick(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Owns the single VRAM port and arbitrates it between the sprite fetcher, the BG/window `Fetcher`, and the CPU bus. During mode 3 it blocks CPU access as hardware does: reads return `0xFF` and writes are dropped. Outside mode 3 it serves the CPU through a one-deep pending slot. It also produces the stall signal that freezes the BG fetcher while a sprite fetch owns VRAM.

## Interface
- No parameters.
- `clk` in 1: system clock, PPU dot rate.
- `reset_n` in 1: asynchronous, active-low reset.
- `lcd_en` in 1: `LCDC[7]`. When 0, the PPU is off and the CPU always has access.
- `mode` in 2: STAT mode. 0 = HBlank, 1 = VBlank, 2 = OAM scan, 3 = drawing.
- `spr_req` in 1 / `spr_addr` in 16: sprite fetcher read request.
- `spr_lock` in 1: sprite fetch sequence in progress. BG is denied while it is high.
- `spr_rdata` out 8 / `spr_rvalid` out 1: sprite read data and its grant strobe.
- `bg_req` in 1 / `bg_addr` in 16: BG fetcher read request (`vram_read_req` / `vram_addr`).
- `bg_rdata` out 8 / `bg_rvalid` out 1 / `bg_stall` out 1: BG read data, grant strobe, and denied-request flag.
- `cpu_req` in 1 / `cpu_we` in 1 / `cpu_addr` in 16 / `cpu_wdata` in 8: CPU access. The request is a level held until `cpu_ack`.
- `cpu_rdata` out 8 / `cpu_ack` out 1: CPU read data and a one-cycle completion pulse.
- `mem_addr` out 13 / `mem_we` out 1 / `mem_wdata` out 8 / `mem_rdata` in 8: VRAM port. Reads are asynchronous. A write commits at the `clk` edge while `mem_we` is high.
- `stall_cnt` out 8: number of cycles `bg_stall` was high in the current mode 3, saturating.
- `arb_state_dbg` out 2: grant of the current cycle. 0 = none, 1 = SPR, 2 = BG, 3 = CPU.

## Operation
- `draw = lcd_en & (mode == 3)`.
- Grant is combinational, evaluated every cycle, with fixed priority:
  1. SPR if `spr_req`.
  2. BG if `bg_req & !spr_lock`.
  3. CPU if `pend & !draw`.
- `mem_addr` is the winner's `addr[12:0]`. With no grant, `mem_addr` = `pend_addr[12:0]` and `mem_we` = 0.
- `spr_rvalid` and `bg_rvalid` equal their grant. `spr_rdata` and `bg_rdata` are `mem_rdata` when granted, else `0xFF`.
- `bg_stall = bg_req & !grant_bg`.
- When `lcd_en` = 0, `spr_req` and `bg_req` are ignored: no grant, no stall, rvalid = 0.
- CPU pending slot (`pend`, `pend_we`, `pend_addr`, `pend_wdata`):
  - Loads when `cpu_req & !pend & !cpu_ack`.
  - Clears in the cycle it completes.
- CPU completion, taken from pending state:
  - CPU granted with `pend_we` = 1: `mem_we` = 1 and `mem_wdata` = `pend_wdata` this cycle; `cpu_ack` next cycle.
  - CPU granted with `pend_we` = 0: `cpu_rdata <= mem_rdata`; `cpu_ack` next cycle.
  - `pend & draw`: blocked. A read sets `cpu_rdata <= 0xFF`. A write is dropped with `mem_we` = 0. `cpu_ack` next cycle either way.
  - `pend & !draw` but a fetcher won: the access waits. No timeout.
- `stall_cnt`:
  - Clears on the cycle `mode` enters 3. Entry is detected against a registered `mode_q`.
  - Increments while `bg_stall` is high, saturating at 255.
  - Holds otherwise.

## Timing
- Reset values: `pend`, `pend_we` = 0; `pend_addr` = 0; `pend_wdata` = 0; `cpu_ack` = 0; `cpu_rdata` = `0xFF`; `stall_cnt` = 0; `mode_q` = 0.
- During reset, the combinational outputs follow the rules above with `pend` = 0.
- Fetcher reads are zero latency: data is valid in the same cycle as the request.
- CPU latency: `cpu_req` rises in cycle N, `pend` is set in N+1, and the access completes in N+1 if granted. `cpu_ack` pulses in N+2. The minimum is 2 cycles.
- The requester drops `cpu_req` in the cycle after the ack. A new request is accepted no earlier than 1 cycle after the ack.
- The mode-3 boundary is evaluated per cycle against the current `mode`. A request pending when mode 3 begins completes as blocked.
- A write granted in the last cycle before mode 3 commits.
- Reset asserted mid-access clears `pend` with no ack. Any write not yet at its edge is lost.

## Test plan
- **Idle CPU write then read, mode 0.** Write `cpu_addr` `0x8010`, `cpu_wdata` `0x5A` → `mem_we` is high for 1 cycle with `mem_addr` `0x0010`, and `cpu_ack` pulses at N+2. Then read `0x8010` → `cpu_rdata` = `0x5A` with ack at N+2.
- **Mode 3 blocking.** Set `lcd_en` = 1, `mode` = 3. CPU reads `0x9800` → `cpu_rdata` = `0xFF` with ack at N+2. CPU writes `0x9800` with `0x11` → `mem_we` never asserts; a later read in mode 0 returns the old value.
- **Fetcher vs CPU collision, mode 2.** `bg_req` with `bg_addr` `0x9C00` in the same cycle the CPU pend is set → BG is granted, and the CPU is granted the following cycle with ack at N+3.
- **Sprite lock.** With `spr_lock` = 1 and `bg_req` = 1 for 6 cycles and `spr_req` on 2 of them → `bg_stall` = 1 for all 6 cycles, `spr_rvalid` on 2 cycles, and `stall_cnt` = 6.
- **`stall_cnt` behaviour.** Hold `bg_stall` for 300 cycles → `stall_cnt` = 255. Re-enter mode 3 → `stall_cnt` = 0.
- **Reset mid-access and LCD off.** Assert `reset_n` = 0 while `pend` = 1 → no `cpu_ack` and `cpu_rdata` = `0xFF`. With `lcd_en` = 0 and `bg_req` = 1 → `bg_rvalid` = 0, `bg_stall` = 0, and the CPU is served normally.
